// File: rtl/dac_axis_elastic_buffer.sv
// Elastic AXIS buffer feeding the RF data converter DAC. It prefills before streaming and reports underruns and fill statistics.
// Optional build macro DAC_EBUF_HOLD_LAST_EN: hold the last word read on m_axis_TDATA while the output is idle.
module dac_axis_elastic_buffer #(
  parameter  int AXIS_DATA_WIDTH = 256,
  parameter  int FIFO_DEPTH      = 16,
  parameter  int PREFILL_LEVEL   = 8,
  parameter  int COUNT_WIDTH     = 16,
  localparam int PTR_W           = $clog2(FIFO_DEPTH),
  localparam int LVL_W           = PTR_W + 1
) (
  input  logic                       axis_CLK,
  input  logic                       axis_RESETN,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_TDATA,
  input  logic                       s_axis_TVALID,
  output logic                       s_axis_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_TDATA,
  output logic                       m_axis_TVALID,
  input  logic                       m_axis_TREADY,
  input  logic                       evrHbMarker,
  input  logic                       statusClear,
  output logic [LVL_W-1:0]           fillLevel,
  output logic [LVL_W-1:0]           hbFillLevel,
  output logic [LVL_W-1:0]           lowWater,
  output logic [COUNT_WIDTH-1:0]     underrunCount,
  output logic                       running
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_PREFILL = LVL_W'(PREFILL_LEVEL);

  logic [AXIS_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [LVL_W-1:0]           r_wr_ptr;
  logic [LVL_W-1:0]           r_rd_ptr;
  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [LVL_W-1:0]           r_hb_fill;
  logic [LVL_W-1:0]           r_low_water;
  logic [COUNT_WIDTH-1:0]     r_underrun_cnt;

  logic [LVL_W-1:0]           w_fill;
  logic                       w_wr;
  logic                       w_rd;
  logic                       w_underrun;
  logic [AXIS_DATA_WIDTH-1:0] w_rd_data;

  // Occupancy from the pointer difference; the extra MSB separates full from empty.
  assign w_fill        = r_wr_ptr - r_rd_ptr;
  assign s_axis_TREADY = axis_RESETN && (w_fill != LVL_FULL);
  assign m_axis_TVALID = (r_state == ST_RUN) && (w_fill != '0);
  assign w_wr          = s_axis_TVALID && s_axis_TREADY;
  assign w_rd          = m_axis_TVALID && m_axis_TREADY;
  assign w_underrun    = (r_state == ST_RUN) && m_axis_TREADY && (w_fill == '0);
  assign w_rd_data     = r_mem[r_rd_ptr[PTR_W-1:0]];

  // NOTE: storage has no reset; the pointers alone define which words are valid.
  always_ff @(posedge axis_CLK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= s_axis_TDATA;
    end
  end

  // NOTE: state is updated with <= so every register sees pre-edge values.
  always_ff @(posedge axis_CLK) begin
    if (!axis_RESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: next state defaults to the current state, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_fill >= LVL_PREFILL) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_underrun)            w_state_nxt = ST_FILL;
      default:                            w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge axis_CLK) begin
    if (!axis_RESETN) begin
      r_hb_fill      <= '0;
      r_low_water    <= LVL_FULL;
      r_underrun_cnt <= '0;
    end else begin
      if (evrHbMarker) r_hb_fill <= w_fill;

      if (evrHbMarker || statusClear) begin
        r_low_water <= LVL_FULL;
      end else if ((r_state == ST_RUN) && (w_fill < r_low_water)) begin
        r_low_water <= w_fill;
      end

      // A clear coinciding with an underrun keeps that event in the fresh count.
      if (statusClear) begin
        r_underrun_cnt <= w_underrun ? COUNT_WIDTH'(1) : '0;
      end else if (w_underrun && (r_underrun_cnt != '1)) begin
        r_underrun_cnt <= r_underrun_cnt + 1'b1;
      end
    end
  end

`ifdef DAC_EBUF_HOLD_LAST_EN
  logic [AXIS_DATA_WIDTH-1:0] r_last_word;

  always_ff @(posedge axis_CLK) begin
    if (!axis_RESETN) begin
      r_last_word <= '0;
    end else if (w_rd) begin
      r_last_word <= w_rd_data;
    end
  end

  assign m_axis_TDATA = m_axis_TVALID ? w_rd_data : r_last_word;
`else
  assign m_axis_TDATA = m_axis_TVALID ? w_rd_data : '0;
`endif

  assign fillLevel     = w_fill;
  assign hbFillLevel   = r_hb_fill;
  assign lowWater      = r_low_water;
  assign underrunCount = r_underrun_cnt;
  assign running       = (r_state == ST_RUN);

endmodule

// File: tb/tb_dac_axis_elastic_buffer.sv
// Directed bench for dac_axis_elastic_buffer. A second instance with a 2-bit counter exercises saturation.
module tb_dac_axis_elastic_buffer;

  localparam int DW    = 256;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          m_ready;
  logic          hb;
  logic          clr;
  logic [DW-1:0] s_data;

  logic          s_ready,  s_ready2;
  logic [DW-1:0] m_data,   m_data2;
  logic          m_valid,  m_valid2;
  logic [LW-1:0] fill,     fill2;
  logic [LW-1:0] hbfill,   hbfill2;
  logic [LW-1:0] lowwater, lowwater2;
  logic [15:0]   ucnt;
  logic [1:0]    ucnt2;
  logic          running,  running2;

  int n_cmp;
  int n_err;
  int s_idx;
  int exp_rd;
  int base;
  int exp_sat [3] = '{2, 3, 3};

  always #5 clk = ~clk;

  dac_axis_elastic_buffer #(
    .AXIS_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PREFILL_LEVEL(8), .COUNT_WIDTH(16)
  ) dut (
    .axis_CLK(clk), .axis_RESETN(rst_n),
    .s_axis_TDATA(s_data), .s_axis_TVALID(s_valid), .s_axis_TREADY(s_ready),
    .m_axis_TDATA(m_data), .m_axis_TVALID(m_valid), .m_axis_TREADY(m_ready),
    .evrHbMarker(hb), .statusClear(clr),
    .fillLevel(fill), .hbFillLevel(hbfill), .lowWater(lowwater),
    .underrunCount(ucnt), .running(running)
  );

  dac_axis_elastic_buffer #(
    .AXIS_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PREFILL_LEVEL(8), .COUNT_WIDTH(2)
  ) dut_sat (
    .axis_CLK(clk), .axis_RESETN(rst_n),
    .s_axis_TDATA(s_data), .s_axis_TVALID(s_valid), .s_axis_TREADY(s_ready2),
    .m_axis_TDATA(m_data2), .m_axis_TVALID(m_valid2), .m_axis_TREADY(m_ready),
    .evrHbMarker(hb), .statusClear(clr),
    .fillLevel(fill2), .hbFillLevel(hbfill2), .lowWater(lowwater2),
    .underrunCount(ucnt2), .running(running2)
  );

  function automatic logic [DW-1:0] mkword(int k);
    logic [31:0] w;
    w = 32'hDAC0_0000 + 32'(k);
    return {8{w}};
  endfunction

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshakes are sampled on the falling edge; the read word is checked against stream order.
  task automatic tick();
    bit            fs;
    bit            fm;
    logic [DW-1:0] md;
    @(negedge clk);
    fs = s_valid && s_ready;
    fm = m_valid && m_ready && rst_n;
    md = m_data;
    @(posedge clk);
    #1;
    if (fm) begin
      check("rd_order", md, mkword(exp_rd));
      exp_rd++;
    end
    if (fs) begin
      s_idx++;
      s_data = mkword(s_idx);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; s_idx = 0; exp_rd = 0; base = 0;
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; hb = 1'b0; clr = 1'b0;
    s_data = mkword(0);

    // Reset state
    tick(); tick();
    check("rst_s_ready",  s_ready,  0);
    check("rst_fill",     fill,     0);
    check("rst_m_valid",  m_valid,  0);
    check("rst_m_data",   m_data,   0);
    check("rst_hbfill",   hbfill,   0);
    check("rst_lowwater", lowwater, DEPTH);
    check("rst_ucnt",     ucnt,     0);
    check("rst_running",  running,  0);

    // Prefill then stream
    rst_n = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    repeat (8) tick();
    check("pf_fill8",    fill,    8);
    check("pf_m_valid0", m_valid, 0);
    check("pf_running0", running, 0);
    tick();
    check("pf_running1", running, 1);
    check("pf_m_valid1", m_valid, 1);
    check("pf_fill9",    fill,    9);
    check("pf_first",    m_data,  mkword(0));
    repeat (20) tick();
    check("stream_fill", fill, 9);

    // Consumer stall until full
    m_ready = 1'b0;
    repeat (40) tick();
    check("full_fill",    fill,    DEPTH);
    check("full_s_ready", s_ready, 0);
    check("full_m_valid", m_valid, 1);
    m_ready = 1'b1;
    tick();
    check("unfull_fill",    fill,    15);
    check("unfull_s_ready", s_ready, 1);
    repeat (5) tick();
    check("resume_fill", fill, 15);

    // Upstream stops: drain, underrun, re-prefill
    s_valid = 1'b0;
    repeat (15) tick();
    check("drain_fill",    fill,    0);
    check("drain_running", running, 1);
    check("drain_m_valid", m_valid, 0);
`ifdef DAC_EBUF_HOLD_LAST_EN
    check("idle_data", m_data, mkword(s_idx - 1));
`else
    check("idle_data", m_data, 0);
`endif
    check("drain_ucnt0", ucnt, 0);
    tick();
    check("ur_running", running,  0);
    check("ur_ucnt1",   ucnt,     1);
    check("ur_lowwater", lowwater, 0);
    s_valid = 1'b1;
    repeat (8) tick();
    check("refill_fill8",   fill,    8);
    check("refill_running", running, 0);
    check("refill_ucnt",    ucnt,    1);
    tick();
    check("rerun_running", running, 1);
    check("rerun_data",    m_data,  mkword(exp_rd));

    // Repeated underruns: 2-bit counter must stick at all-ones
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b0;
      repeat (10) tick();
      check("sat_running0", running, 0);
      check("sat_ucnt",     ucnt,    2 + i);
      check("sat_ucnt2",    ucnt2,   exp_sat[i]);
      s_valid = 1'b1;
      repeat (9) tick();
      check("sat_running1", running, 1);
    end

    // Heartbeat every 128 cycles with m_ready low one cycle in 16
    check("hb_lw_pre", lowwater, 0);
    for (int c = 0; c < 256; c++) begin
      m_ready = (c % 16) != 15;
      hb      = (c % 128) == 127;
      tick();
      if (c == 111) check("hb_fill_c111", fill, 16);
      if (c == 112) check("hb_fill_c112", fill, 15);
      if (c == 126) begin
        check("hb_lw_c126", lowwater, 0);
        check("hb_hb_c126", hbfill,   0);
      end
      if (c == 127) begin
        check("hb_hb_c127",   hbfill,   15);
        check("hb_lw_c127",   lowwater, 16);
        check("hb_fill_c127", fill,     16);
      end
      if (c == 128) check("hb_lw_c128", lowwater, 16);
      if (c == 129) check("hb_lw_c129", lowwater, 15);
      if (c == 255) begin
        check("hb_hb_c255", hbfill,   15);
        check("hb_lw_c255", lowwater, 16);
      end
    end
    hb = 1'b0;

    // Clear coincident with an underrun
    m_ready = 1'b1; s_valid = 1'b0;
    repeat (16) tick();
    check("clr_pre_fill",    fill,    0);
    check("clr_pre_running", running, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ucnt",     ucnt,     1);
    check("clr_ucnt2",    ucnt2,    1);
    check("clr_lowwater", lowwater, 16);
    check("clr_running",  running,  0);

    // Clear and heartbeat together
    s_valid = 1'b1;
    repeat (3) tick();
    hb = 1'b1; clr = 1'b1;
    tick();
    hb = 1'b0; clr = 1'b0;
    check("clrhb_hbfill", hbfill,   3);
    check("clrhb_lw",     lowwater, 16);
    check("clrhb_ucnt",   ucnt,     0);

    // Reset mid-stream at fill 12
    repeat (5) tick();
    check("pre_rst_running", running, 1);
    check("pre_rst_fill",    fill,    9);
    m_ready = 1'b0;
    repeat (3) tick();
    check("pre_rst_fill12", fill, 12);
    rst_n = 1'b0;
    tick();
    check("mid_rst_fill",     fill,     0);
    check("mid_rst_m_valid",  m_valid,  0);
    check("mid_rst_running",  running,  0);
    check("mid_rst_ucnt",     ucnt,     0);
    check("mid_rst_s_ready",  s_ready,  0);
    check("mid_rst_m_data",   m_data,   0);
    check("mid_rst_lowwater", lowwater, 16);
    check("mid_rst_hbfill",   hbfill,   0);
    base = s_idx;
    exp_rd = s_idx;
    rst_n = 1'b1; m_ready = 1'b1;
    repeat (9) tick();
    check("post_rst_running", running, 1);
    check("post_rst_first",   m_data,  mkword(base));
    repeat (10) tick();
    check("post_rst_fill", fill, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
